f_minmax_pipe: RTL and testbench

Synthesizable, pipelined floating-point min/max unit operating on FloPoCo-format single-precision operands. It is the hardware implementation of the min/max operation whose behavioural DPI model is used in simulation. The unit sits in the FPU execute path between issue and writeback and uses a valid/ready handshake on both ends. It returns results with RISC-V FMIN/FMAX semantics, carrying a tag for writeback association.

---
 rtl/f_minmax_pipe.sv | 127 ++++++++++++
 tb/tb_f_minmax_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_minmax_pipe.sv
// rtl/f_minmax_pipe.sv - two-stage FloPoCo min/max with RISC-V FMIN/FMAX semantics
module f_minmax_pipe #(
    parameter int FLEN   = 34,
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [FLEN-1:0]  a,
    input  logic [FLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  res,
    output logic [TAG_W-1:0] tag_out
);
    // Two extra key bits keep infinity strictly above the all-ones normal.
    localparam int KW = EXP_W + FRAC_W + 2;
    localparam int SB = FLEN - 3;
    localparam logic [FLEN-1:0] CANON_NAN =
        {2'b11, 1'b0, {EXP_W{1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic [KW-1:0] key_of(input logic [FLEN-1:0] x);
        logic [KW-1:0] k;
        k = '1;
        case (x[FLEN-1 -: 2])
            2'b00:   k = '0;
            2'b01:   k = {2'b01, x[EXP_W+FRAC_W-1:0]};
            default: k = '1;
        endcase
        return k;
    endfunction

    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv;

    logic             op_q;
    logic [TAG_W-1:0] tag1_q;
    logic [FLEN-1:0]  a_q, b_q;
    logic             lt_q, eq_q, nan_a_q, nan_b_q;

    logic [FLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag2_q;

    logic [KW-1:0] key_a, key_b;
    logic          lt_d, eq_d, nan_a_d, nan_b_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign key_a   = key_of(a);
    assign key_b   = key_of(b);
    assign nan_a_d = (a[FLEN-1 -: 2] == 2'b11);
    assign nan_b_d = (b[FLEN-1 -: 2] == 2'b11);

    // Differing signs decide on sign alone, so -0 orders below +0.
    always_comb begin
        lt_d = 1'b0;
        eq_d = 1'b0;
        if (a[SB] != b[SB]) begin
            lt_d = a[SB];
        end else begin
            lt_d = a[SB] ? (key_b < key_a) : (key_a < key_b);
            eq_d = (key_a == key_b);
        end
    end

    always_comb begin
        res_d = a_q;
        if (nan_a_q && nan_b_q)
            res_d = CANON_NAN;
        else if (nan_a_q)
            res_d = b_q;
        else if (nan_b_q)
            res_d = a_q;
        else if (op_q)
            res_d = lt_q ? b_q : a_q;
        else
            res_d = (lt_q || eq_q) ? a_q : b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_q       <= 1'b0;
            tag1_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            nan_a_q    <= 1'b0;
            nan_b_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            op_q       <= op;
            tag1_q     <= tag_in;
            a_q        <= a;
            b_q        <= b;
            lt_q       <= lt_d;
            eq_q       <= eq_d;
            nan_a_q    <= nan_a_d;
            nan_b_q    <= nan_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            tag2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            res_q      <= res_d;
            tag2_q     <= tag1_q;
        end
    end

    assign out_valid = s2_valid_q;
    assign res       = res_q;
    assign tag_out   = tag2_q;

endmodule

// File: tb/tb_f_minmax_pipe.sv
// tb/tb_f_minmax_pipe.sv - scoreboard bench for f_minmax_pipe against a rank-based reference model
module tb_f_minmax_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [33:0] a = '0;
    logic [33:0] b = '0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [33:0] res;
    logic [3:0]  tag_out;

    f_minmax_pipe #(.FLEN(34), .EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] res;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [33:0] mk(input logic [1:0] e, input logic s,
                                       input logic [7:0] ex, input logic [22:0] f);
        return {e, s, ex, f};
    endfunction

    // Maps each non-NaN operand onto the real number line as an odd integer so that -0 < +0.
    function automatic longint rank(input logic [33:0] x);
        longint mag;
        longint r;
        case (x[33:32])
            2'b00:   mag = 0;
            2'b01:   mag = longint'({1'b1, x[30:0]});
            default: mag = 64'sd8589934592;
        endcase
        r = 2 * mag + 1;
        return x[31] ? -r : r;
    endfunction

    function automatic logic [33:0] ref_minmax(input bit o, input logic [33:0] x, input logic [33:0] y);
        bit na, nb;
        na = (x[33:32] == 2'b11);
        nb = (y[33:32] == 2'b11);
        if (na && nb) return 34'h3_0040_0000;
        if (na) return y;
        if (nb) return x;
        if (o) return (rank(x) >= rank(y)) ? x : y;
        return (rank(x) <= rank(y)) ? x : y;
    endfunction

    function automatic logic [33:0] rnd_op();
        logic [1:0]  e;
        logic [7:0]  ex;
        logic [22:0] f;
        e  = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
        ex = ($urandom_range(0, 3) == 0) ? 8'(8'h7E + $urandom_range(0, 3)) : 8'($urandom);
        f  = ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 3)) : 23'($urandom);
        return mk(e, 1'($urandom), ex, f);
    endfunction

    function automatic logic [33:0] rnd_partner(input logic [33:0] x);
        logic [33:0] y;
        case ($urandom_range(0, 3))
            0:       y = x;
            1:       y = {x[33:23], 23'($urandom_range(0, 3))};
            2:       y = {x[33:32], ~x[31], x[30:0]};
            default: y = rnd_op();
        endcase
        return y;
    endfunction

    task automatic step(input bit v, input bit o, input logic [33:0] aa, input logic [33:0] bb,
                        input logic [3:0] t, input logic [33:0] ex, input bit ordy,
                        input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = aa;
        b         = bb;
        tag_in    = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.res = ex;
            e.tag = t;
            e.cyc = cyc;
            e.lat = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            step(0, 0, '0, '0, '0, '0, 1, 1, acc);
            n++;
        end
        step(0, 0, '0, '0, '0, '0, 1, 1, acc);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every handshake the DUT presents must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got res %h tag %0d expected none", res, tag_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("res_tag%0d", e.tag), 64'(res), 64'(e.res));
                    check("tag_out", 64'(tag_out), 64'(e.tag));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    localparam logic [33:0] P1   = 34'h1_3F80_0000;
    localparam logic [33:0] P2   = 34'h1_4000_0000;
    localparam logic [33:0] M5   = 34'h1_C0A0_0000;
    localparam logic [33:0] CNAN = 34'h3_0040_0000;

    initial begin
        bit          acc;
        int          n_acc;
        int          tag_next;
        logic [33:0] pz, nz, pz2, pinf, ninf, pmax, nmax, nan1, nan2;
        logic [33:0] x, y;
        bit          o;

        pz   = mk(2'b00, 1'b0, 8'h12, 23'h5);
        pz2  = mk(2'b00, 1'b0, 8'h34, 23'h77);
        nz   = mk(2'b00, 1'b1, 8'h00, 23'h9);
        pinf = mk(2'b10, 1'b0, 8'hAA, 23'h1);
        ninf = mk(2'b10, 1'b1, 8'h00, 23'h0);
        pmax = mk(2'b01, 1'b0, 8'hFF, 23'h7FFFFF);
        nmax = mk(2'b01, 1'b1, 8'hFF, 23'h7FFFFF);
        nan1 = mk(2'b11, 1'b1, 8'h55, 23'h123);
        nan2 = mk(2'b11, 1'b0, 8'h01, 23'h0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_res", 64'(res), 64'd0);
        check("reset_tag", 64'(tag_out), 64'd0);

        step(1, 0, P1, P2, 4'd3, P1, 1, 1, acc);
        step(1, 1, nz, pz, 4'd4, pz, 1, 1, acc);
        step(1, 0, pz, nz, 4'd5, nz, 1, 1, acc);
        step(1, 1, nan1, M5, 4'd6, M5, 1, 1, acc);
        step(1, 0, nan1, nan2, 4'd7, CNAN, 1, 1, acc);
        step(1, 0, ninf, nmax, 4'd8, ninf, 1, 1, acc);
        step(1, 1, pinf, pmax, 4'd9, pinf, 1, 1, acc);
        step(1, 0, pz, pz2, 4'd10, pz, 1, 1, acc);
        step(1, 1, pz2, pz, 4'd11, pz2, 1, 1, acc);
        step(1, 0, M5, nan2, 4'd12, M5, 1, 1, acc);
        drain();

        n_acc = 0;
        tag_next = 0;
        for (int k = 0; k < 5; k++) begin
            step(1, 1, mk(2'b01, 1'b0, 8'(8'h80 + tag_next), 23'h0), P1, 4'(tag_next),
                 mk(2'b01, 1'b0, 8'(8'h80 + tag_next), 23'h0), 0, 0, acc);
            if (acc) begin
                n_acc++;
                tag_next++;
            end
            if (k >= 2) check("bp_res_hold", 64'(res), 64'(mk(2'b01, 1'b0, 8'h80, 23'h0)));
        end
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_tag_hold", 64'(tag_out), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step(tag_next < 4, 1, mk(2'b01, 1'b0, 8'(8'h80 + tag_next), 23'h0), P1, 4'(tag_next),
                 mk(2'b01, 1'b0, 8'(8'h80 + tag_next), 23'h0), 1, 0, acc);
            if (acc) tag_next++;
            check("bp_no_gap", 64'(out_valid), 64'd1);
        end
        drain();

        n_acc = 0;
        for (int k = 0; k < 1000; k++) begin
            x = rnd_op();
            y = rnd_partner(x);
            o = 1'($urandom);
            step(1, o, x, y, 4'(k), ref_minmax(o, x, y), 1, 1, acc);
            if (acc) n_acc++;
        end
        check("throughput_accepts", 64'(n_acc), 64'd1000);
        drain();

        for (int k = 0; k < 500; k++) begin
            x = rnd_op();
            y = rnd_partner(x);
            o = 1'($urandom);
            step(1'($urandom), o, x, y, 4'(k), ref_minmax(o, x, y),
                 $urandom_range(0, 3) != 0, 0, acc);
        end
        drain();

        step(1, 0, P2, P1, 4'd1, P1, 0, 0, acc);
        step(1, 1, P2, P1, 4'd2, P2, 0, 0, acc);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_res", 64'(res), 64'd0);
        check("midrst_tag", 64'(tag_out), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        step(1, 1, M5, nz, 4'd13, nz, 1, 1, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
